// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, standard HDMI ACR N values, meter states and helpers.
package audio_pkg;
    localparam int CTS_W  = 20;
    localparam int N_32K  = 4096;
    localparam int N_44K1 = 6272;
    localparam int N_48K  = 6144;
    localparam int N_192K = 24576;
    typedef enum logic {IDLE, MEASURE} state_t;
    function automatic logic [CTS_W-1:0] abs_diff(input logic [CTS_W-1:0] a, input logic [CTS_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
endpackage

// File: rtl/audio_acr_meter.sv
// audio_acr_meter: measures HDMI ACR CTS as clk cycles per N/128 audio strobes and flags lock.
module audio_acr_meter
    import audio_pkg::*;
#(
    parameter int N   = N_192K,
    parameter int TOL = 2,
    parameter int TMO = (1 << CTS_W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             audio_stb,
    output logic [CTS_W-1:0] n_value,
    output logic [CTS_W-1:0] cts,
    output logic             cts_stb,
    output logic             locked
);
    localparam int WIN = N / 128;
    localparam int SW  = $clog2(WIN + 1);
    localparam logic [CTS_W-1:0] TOL_V = CTS_W'(TOL);
    state_t           state, state_nx;
    logic [CTS_W-1:0] cyc, prev, cyc_inc;
    logic [SW-1:0]    scnt;
    logic             has_prev, timeout, close;
    assign n_value = CTS_W'(N);
    assign cyc_inc = cyc + CTS_W'(1);
    // timeout outranks a coincident strobe, so that strobe can neither close nor open a window
    always_comb begin
        timeout  = state == MEASURE && cyc == CTS_W'(TMO);
        close    = state == MEASURE && !timeout && audio_stb && scnt == SW'(WIN - 1);
        state_nx = timeout ? IDLE : (state == IDLE && audio_stb) ? MEASURE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cyc      <= '0;
            scnt     <= '0;
            cts      <= '0;
            prev     <= '0;
            cts_stb  <= 1'b0;
            locked   <= 1'b0;
            has_prev <= 1'b0;
        end else begin
            state   <= state_nx;
            cts_stb <= close;
            if (state == IDLE) begin
                cyc      <= '0;
                scnt     <= '0;
                has_prev <= 1'b0;
            end else if (timeout) begin
                cyc    <= '0;
                scnt   <= '0;
                locked <= 1'b0;
            end else if (close) begin
                cts      <= cyc_inc;
                prev     <= cyc_inc;
                cyc      <= '0;
                scnt     <= '0;
                has_prev <= 1'b1;
                locked   <= has_prev && abs_diff(cyc_inc, prev) <= TOL_V;
            end else begin
                cyc  <= cyc_inc;
                scnt <= scnt + SW'(audio_stb);
            end
        end
    end
endmodule

// File: tb/tb_audio_acr_meter.sv
// tb_audio_acr_meter: directed scoreboard bench for the ACR meter with a shortened timeout.
module tb_audio_acr_meter;
    localparam int N   = 256;
    localparam int WIN = N / 128;
    localparam int TOL = 2;
    localparam int TMO = 300;
    typedef struct { int t; int c; logic l; } exp_t;
    logic        clk = 1'b0, reset = 1'b1, audio_stb = 1'b0;
    logic [19:0] n_value, cts;
    logic        cts_stb, locked;
    int          total = 0, bad = 0, now = 0;
    exp_t        q[$];
    bit          open = 0, has_prev = 0, lock_m = 0;
    int          t_open = 0, k = 0, prev_m = 0, cts_m = 0;
    audio_acr_meter #(.N(N), .TOL(TOL), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .audio_stb(audio_stb),
        .n_value(n_value), .cts(cts), .cts_stb(cts_stb), .locked(locked)
    );
    always #5 clk = ~clk;
    always @(posedge clk) now++;
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // Reference: window length is the distance in edges between opening and closing strobe.
    task automatic model(input bit s);
        int c;
        if (open && now - t_open == TMO + 1) begin
            open = 0; lock_m = 0; has_prev = 0;
            return;
        end
        if (!s) return;
        if (!open) begin
            open = 1; t_open = now; k = 0;
            return;
        end
        k++;
        if (k == WIN) begin
            c = now - t_open;
            lock_m = has_prev && ((c > prev_m) ? c - prev_m : prev_m - c) <= TOL;
            has_prev = 1; prev_m = c; cts_m = c;
            q.push_back('{now, c, lock_m});
            t_open = now; k = 0;
        end
    endtask
    task automatic step(input bit s);
        audio_stb = s;
        @(posedge clk);
        #1;
        audio_stb = 0;
        model(s);
    endtask
    task automatic gap(input int g);
        repeat (g - 1) step(0);
        step(1);
    endtask
    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_cts", cts, 0);
        chk("rst_locked", locked, 0);
        chk("rst_stb", cts_stb, 0);
        chk("rst_n_value", n_value, N);
        reset = 0;
        open = 0; has_prev = 0; lock_m = 0; cts_m = 0; prev_m = 0;
    endtask
    always @(negedge clk) begin
        if (!reset && cts_stb) begin
            exp_t e;
            chk("stb_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stb_time", now, e.t);
                chk("stb_cts", cts, e.c);
                chk("stb_locked", locked, e.l);
            end
        end
    end
    initial begin
        do_reset(3);
        step(1);
        repeat (5) gap(10);
        chk("locked_p10", locked, 1);
        repeat (7) gap(13);
        chk("locked_p13", locked, 1);
        repeat (2) gap(12);
        chk("tol_edge_locked", locked, 1);
        gap(14);
        gap(13);
        chk("tol_over_unlocked", locked, 0);
        repeat (2) gap(10);
        repeat (TMO + 20) step(0);
        chk("tmo_locked", locked, 0);
        chk("tmo_cts_held", cts, cts_m);
        chk("tmo_no_stb", q.size(), 0);
        step(1);
        repeat (4) gap(10);
        chk("restart_locked", locked, 1);
        repeat (4) gap(1);
        chk("b2b_locked", locked, 1);
        chk("b2b_cts", cts, 2);
        gap(10);
        do_reset(2);
        repeat (5) step(0);
        chk("post_rst_cts", cts, 0);
        step(1);
        repeat (2) gap(10);
        chk("post_rst_win_cts", cts, 20);
        repeat (TMO) step(0);
        step(1);
        chk("coll_locked", locked, 0);
        repeat (3) gap(10);
        chk("coll_cts", cts, 20);
        repeat (5) step(0);
        chk("queue_drained", q.size(), 0);
        chk("n_value", n_value, N);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
